cordic_stream: RTL

- Parametrised, handshaked iterative CORDIC engine, one transaction in flight. Successor to the fixed 11-angle sin/cos engine.
- Two modes:
  - Rotation: z angle -> cos(z), sin(z).
  - Vectoring: (x,y) -> magnitude, atan2(y,x).
- Any width, fraction split and iteration count; full-circle quadrant handling; gain compensated internally.
- Sits between the Goertzel coefficient/phase logic and the downstream multipliers. Feeds one angle or vector per valid/ready handshake.

---
 rtl/cordic_pkg.sv | 54 +++++
 rtl/cordic_gain_mult.sv | 18 +
 rtl/cordic_stream.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and Q4.60 constants for the iterative CORDIC engine.
// Fixed-point constants are scaled down to the port format by arithmetic right shift.
package cordic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        ITER,
        SCALE,
        DONE
    } state_e;

    localparam int unsigned QF   = 60;
    localparam int unsigned NTAB = 64;
    localparam real         Q60R = 1152921504606846976.0;

    localparam logic signed [63:0] PI_Q60   = 64'sh3243F6A8885A308D;
    localparam logic signed [63:0] PI_2_Q60 = 64'sh1921FB54442D1846;
    localparam logic signed [63:0] K_Q60    = 64'(longint'(0.6072529350088812561694 * Q60R));

    typedef logic signed [63:0] atan_tab_t [NTAB];

    // atan(2^-i) in Q4.60; small angles use a short Taylor series, tiny ones equal 2^-i.
    function automatic atan_tab_t atan_init();
        atan_tab_t t;
        real       x;
        real       a;
        for (int i = 0; i < 64; i++) begin
            x = 1.0 / (2.0 ** i);
            case (i)
                0:       a = 0.7853981633974483;
                1:       a = 0.4636476090008061;
                2:       a = 0.24497866312686414;
                3:       a = 0.12435499454676144;
                default: a = x - (x ** 3) / 3.0 + (x ** 5) / 5.0 - (x ** 7) / 7.0 + (x ** 9) / 9.0;
            endcase
            if (i < 30) begin
                t[i] = 64'(longint'(a * Q60R));
            end else if (i <= 60) begin
                t[i] = 64'sd1 <<< (60 - i);
            end else begin
                t[i] = 64'sd0;
            end
        end
        return t;
    endfunction

    localparam atan_tab_t ATAN_TAB = atan_init();

    function automatic logic signed [63:0] atan_q60(input logic [5:0] idx);
        return ATAN_TAB[idx];
    endfunction

endpackage

// File: rtl/cordic_gain_mult.sv
// Combinational multiply by the CORDIC gain K, result kept in the operand's Q format.
module cordic_gain_mult
    import cordic_pkg::*;
#(
    parameter int unsigned W = 34
) (
    input  logic signed [W-1:0] a,
    output logic signed [W-1:0] p_c
);

    localparam int unsigned PW = W + 64;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(K_Q60);
    assign p_c  = W'(prod >>> QF);

endmodule

// File: rtl/cordic_stream.sv
// Handshaked iterative CORDIC: rotation (angle -> cos/sin) and vectoring (x,y -> mag/atan2).
// One transaction in flight; internal x/y carry two guard bits for CORDIC growth.
module cordic_stream
    import cordic_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned FW    = 29,
    parameter int unsigned NITER = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    input  logic signed [DW-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_x,
    output logic signed [DW-1:0] out_y,
    output logic signed [DW-1:0] out_z,
    output logic                 out_err,
    output logic                 busy
);

    localparam int unsigned W  = DW + 2;
    localparam int unsigned SH = QF - FW;

    localparam logic signed [DW-1:0] PI_F   = DW'(PI_Q60 >>> SH);
    localparam logic signed [DW-1:0] PI_2_F = DW'(PI_2_Q60 >>> SH);
    localparam logic signed [W-1:0]  ONE_W  = W'(64'sd1 <<< FW);
    localparam logic [5:0]           LAST   = 6'(NITER - 1);

    state_e               state_q, state_d;
    logic                 mode_q, mode_d;
    logic                 neg_q, neg_d;
    logic                 err_q, err_d;
    logic [5:0]           iter_q, iter_d;
    logic signed [W-1:0]  x_q, x_d, y_q, y_d;
    logic signed [DW-1:0] z_q, z_d;
    logic signed [DW-1:0] out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
    logic                 out_err_q, out_err_d, out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d, busy_q, busy_d;

    logic signed [W-1:0]  gain_a_c, gain_p_c, xs_c, ys_c;
    logic signed [DW-1:0] atan_c;
    logic                 dpos_c;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [W-1:0] v);
        if (v[W-1:DW-1] == {(W - DW + 1){v[W-1]}}) begin
            return v[DW-1:0];
        end
        return v[W-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
    endfunction

    // One multiplier serves both the rotation start value (K * 1.0) and vectoring gain removal.
    assign gain_a_c = (state_q == REDUCE) ? ONE_W : x_q;

    cordic_gain_mult #(.W(W)) u_gain (
        .a   (gain_a_c),
        .p_c (gain_p_c)
    );

    assign xs_c   = x_q >>> iter_q;
    assign ys_c   = y_q >>> iter_q;
    assign atan_c = DW'(atan_q60(iter_q) >>> SH);
    assign dpos_c = mode_q ? y_q[W-1] : ~z_q[DW-1];

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        neg_d       = neg_q;
        err_d       = err_q;
        iter_d      = iter_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_z_d     = out_z_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    x_d     = W'(in_x);
                    y_d     = W'(in_y);
                    z_d     = in_z;
                    neg_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                iter_d  = '0;
                state_d = ITER;
                if (!mode_q) begin
                    x_d = gain_p_c;
                    y_d = '0;
                    if (z_q > PI_F || z_q < -PI_F) begin
                        err_d   = 1'b1;
                        x_d     = '0;
                        z_d     = '0;
                        state_d = SCALE;
                    end else if (z_q > PI_2_F) begin
                        z_d   = z_q - PI_F;
                        neg_d = 1'b1;
                    end else if (z_q < -PI_2_F) begin
                        z_d   = z_q + PI_F;
                        neg_d = 1'b1;
                    end
                end else begin
                    // A zero vector has no defined angle: report all zeros.
                    if (x_q == '0 && y_q == '0) begin
                        z_d     = '0;
                        state_d = SCALE;
                    end else if (x_q[W-1]) begin
                        x_d = -x_q;
                        y_d = -y_q;
                        z_d = y_q[W-1] ? -PI_F : PI_F;
                    end else begin
                        z_d = '0;
                    end
                end
            end
            ITER: begin
                if (dpos_c) begin
                    x_d = x_q - ys_c;
                    y_d = y_q + xs_c;
                    z_d = z_q - atan_c;
                end else begin
                    x_d = x_q + ys_c;
                    y_d = y_q - xs_c;
                    z_d = z_q + atan_c;
                end
                iter_d = iter_q + 6'd1;
                if (iter_q == LAST) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                out_z_d     = z_q;
                out_err_d   = err_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
                if (!mode_q) begin
                    out_x_d = sat_dw(neg_q ? -x_q : x_q);
                    out_y_d = sat_dw(neg_q ? -y_q : y_q);
                end else begin
                    out_x_d = sat_dw(gain_p_c);
                    out_y_d = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            iter_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            iter_q      <= iter_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_z_q     <= out_z_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_z     = out_z_q;
    assign out_err   = out_err_q;

endmodule
